cbi980_tx_serializer: RTL and testbench
=======================================

CBI980_TX_SERIALIZER -- requirements
Module: cbi980_tx_serializer

Interface
REQ-001 Parameter: WORD_W, default 32, sample word width; only 32 is supported.
REQ-002 Port: clk  in  1  sole clock, all logic on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-low.
REQ-004 Port: en  in  1  transmit enable (CR txen).
REQ-005 Port: mclk_rate  in  3  bit-clock divider exponent; sck half-period = 2^mclk_rate clk cycles.
REQ-006 Port: octet_cnt  in  3  octets per slot; 0 treated as 1, 5..7 treated as 4.
REQ-007 Port: rjust  in  1  1 = slot data in word[N-1:0]; 0 = slot data in word[31:32-N]; N = 8*octets.
REQ-008 Port: lsb_first  in  1  1 = least significant slot bit first.
REQ-009 Port: t0_data, t1_data  in  32 each  channel 0/1 TX FIFO head words.
REQ-010 Port: t0_valid, t1_valid  in  1 each  FIFO non-empty.
REQ-011 Port: t0_ready, t1_ready  out  1 each  single-cycle pop strobe.
REQ-012 Port: sck  out  1  serial bit clock.
REQ-013 Port: ws  out  1  word select; 0 = channel 0 slot, 1 = channel 1 slot.
REQ-014 Port: sd  out  1  serial data.
REQ-015 Port: tx_unf  out  2  per-channel underflow, one-cycle pulse; bit 1 = channel 1.

Function
REQ-016 States: IDLE, SLOT0, SLOT1.
REQ-017 IDLE: sck=0, ws=0, sd=0, both ready=0, divider held at 0.
REQ-018 IDLE->SLOT0 in the first cycle with en=1; mclk_rate, octet_cnt, rjust and lsb_first are latched then, and are latched again only at each SLOT0 entry.
REQ-019 Tick: the divider counts 0..2^rate-1, and sck toggles on the cycle after the count reaches its maximum; a 1->0 toggle is a falling tick.
REQ-020 Slot entry cycle: the channel's ready=1 for exactly that cycle, ws takes the slot value, and sd takes the first slot bit.
REQ-021 Each slot carries exactly N bits; sd advances one bit on each falling tick; sd and ws change only at falling ticks or at slot entry.
REQ-022 Bit order: left-justified with MSB first starts at word[31]; with lsb_first it starts at word[32-N]; right-justified with MSB first starts at word[N-1]; with lsb_first it starts at word[0].
REQ-023 Falling tick ending bit N of SLOT0: go to SLOT1 and pop channel 1.
REQ-024 Falling tick ending bit N of SLOT1: if en=1, go to SLOT0 and pop channel 0; otherwise go to IDLE.
REQ-025 en=0 mid-frame: the current frame completes unchanged, then the block idles.
REQ-026 Underflow: valid=0 at slot entry -> ready still pulses, the slot transmits all zeros, and the channel's tx_unf pulses high in the same cycle.
REQ-027 At slot entry the word is captured into a shift register; later changes on t*_data have no effect on the slot.
REQ-028 The frame period is 2*N*2^(rate+1) clk cycles; there are no gaps between slots or frames while en=1.

Reset
REQ-029 rst low: state=IDLE, sck=0, ws=0, sd=0, t0_ready=0, t1_ready=0, tx_unf=0, divider=0, bit counter=0, shift register=0, latched config = {rate 0, octets 1, rjust 0, lsb_first 0}.
REQ-030 Reset mid-slot aborts the transfer immediately; no ready or tx_unf pulse is emitted on reset release.

Structure
REQ-031 Shared package cbi980_pkg holds the slot-state enum, the LCFR field widths, and the octet clamp constants (min 1, max 4).
REQ-032 One sub-module, cbi980_clkdiv, generates the tick, falling-tick and sck outputs from the latched rate; it is held cleared by a clear input in IDLE.

Verification
REQ-033 rate=0, octets=1, rjust=0, lsb=0, t0=0xA5000000 -> ws=0, and sd = 1,0,1,0,0,1,0,1 with each bit lasting 2 clk cycles and t0_ready pulsing once.
REQ-034 rate=1, octets=2, rjust=1, lsb=1, t1=0x00001234 -> the SLOT1 sd sequence is 0,0,1,0,1,1,0,0,0,1,0,0,1,0,0,0, with each bit lasting 4 cycles.
REQ-035 t1_valid=0 at SLOT1 entry -> t1_ready=1 and tx_unf=2'b10 for 1 cycle, followed by 8 zero bits on sd.
REQ-036 Drop en during SLOT0 -> SLOT1 completes, the block enters IDLE, and sck, ws and sd are all 0 with no further ready pulses.
REQ-037 octet_cnt=0 and then octet_cnt=7 -> the slot length is 8 and 32 bits respectively; a change to octet_cnt mid-frame takes effect only at the next SLOT0 entry.
REQ-038 Assert rst at bit 5 of SLOT0 -> all outputs are 0 asynchronously, and the first frame after release and en=1 is correct.

Source files
------------

// File: rtl/cbi980_pkg.sv
// cbi980_pkg -- shared definitions for the cbi980 TX serializer.
//   slot_state_e  : frame state (idle, channel-0 slot, channel-1 slot)
//   RATE_W/OCT_W  : LCFR field widths (bit-clock rate, octets per slot)
//   OCT_MIN/MAX   : legal octet range; out-of-range requests are clamped
//   clamp_octets  : maps a raw octet request onto OCT_MIN..OCT_MAX
//   order_slot    : extracts the slot from a 32-bit word and arranges it so
//                   the first bit to transmit is bit 31 and later bits follow
//                   downward; bits below the slot are zero
package cbi980_pkg;

  localparam int unsigned RATE_W = 3;
  localparam int unsigned OCT_W  = 3;

  localparam logic [OCT_W-1:0] OCT_MIN = 3'd1;
  localparam logic [OCT_W-1:0] OCT_MAX = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SLOT0,
    ST_SLOT1
  } slot_state_e;

  function automatic logic [OCT_W-1:0] clamp_octets(input logic [OCT_W-1:0] oct);
    logic [OCT_W-1:0] res;
    res = oct;
    if (oct < OCT_MIN) res = OCT_MIN;
    if (oct > OCT_MAX) res = OCT_MAX;
    return res;
  endfunction

  // oct must already be clamped (1..4), so the slot is 8..32 bits wide.
  function automatic logic [31:0] order_slot(input logic [31:0]      word,
                                             input logic [OCT_W-1:0] oct,
                                             input logic             rjust,
                                             input logic             lsb_first);
    logic [5:0]  nbits;
    logic [5:0]  pad;
    logic [31:0] ones;
    logic [31:0] slot;
    logic [31:0] res;
    nbits = {oct, 3'b000};
    pad   = 6'd32 - nbits;
    ones  = '1;
    // Slot value right-aligned in 'slot', upper bits zero.
    slot  = rjust ? (word & (ones >> pad)) : (word >> pad);
    // Full 32-bit reversal puts slot bit 0 at bit 31 and leaves the
    // unused low bits zero, which is exactly the LSB-first order.
    if (lsb_first) res = {<<{slot}};
    else           res = slot << pad;
    return res;
  endfunction

endpackage

// File: rtl/cbi980_clkdiv.sv
// cbi980_clkdiv -- bit-clock divider for the cbi980 TX serializer.
//   clk, rst  : clock, asynchronous active-low reset
//   clear_i   : holds counter and sck at 0 (used while the serializer idles)
//   rate_i    : sck half-period is 2^rate_i clk cycles
//   tick_o    : counter at its maximum this cycle; sck toggles next cycle
//   fall_o    : tick where sck goes 1->0 next cycle
//   sck_o     : serial bit clock
module cbi980_clkdiv
  import cbi980_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic [RATE_W-1:0] rate_i,
  output logic              tick_o,
  output logic              fall_o,
  output logic              sck_o
);

  logic [6:0] cnt_q, cnt_d;
  logic [6:0] cnt_max;
  logic       sck_q, sck_d;

  always_comb begin
    cnt_max = 7'((8'd1 << rate_i) - 8'd1);
    tick_o  = !clear_i && (cnt_q == cnt_max);
    fall_o  = tick_o && sck_q;
    cnt_d   = cnt_q + 7'd1;
    sck_d   = sck_q;
    if (clear_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (tick_o) begin
      cnt_d = '0;
      sck_d = ~sck_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o = sck_q;

endmodule

// File: rtl/cbi980_tx_serializer.sv
// cbi980_tx_serializer -- two-channel frame serializer (ws/sck/sd).
//   clk, rst              : clock, asynchronous active-low reset
//   en                    : transmit enable; checked at frame boundaries
//   mclk_rate             : sck half-period = 2^mclk_rate clk cycles
//   octet_cnt             : octets per slot (clamped to 1..4)
//   rjust, lsb_first      : slot placement within the word, bit order
//   t0_/t1_data, _valid   : channel FIFO head words and non-empty flags
//   t0_/t1_ready          : one-cycle pop strobe at slot entry
//   sck, ws, sd           : serial clock, word select, serial data
//   tx_unf                : per-channel underflow pulse (bit 1 = channel 1)
// Configuration is latched only on entry to the channel-0 slot.
module cbi980_tx_serializer
  import cbi980_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [2:0]        mclk_rate,
  input  logic [2:0]        octet_cnt,
  input  logic              rjust,
  input  logic              lsb_first,
  input  logic [WORD_W-1:0] t0_data,
  input  logic [WORD_W-1:0] t1_data,
  input  logic              t0_valid,
  input  logic              t1_valid,
  output logic              t0_ready,
  output logic              t1_ready,
  output logic              sck,
  output logic              ws,
  output logic              sd,
  output logic [1:0]        tx_unf
);

  slot_state_e       state_q, state_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic [OCT_W-1:0]  oct_q, oct_d;
  logic              rjust_q, rjust_d;
  logic              lsb_q, lsb_d;
  logic [31:0]       sh_q, sh_d;
  logic [5:0]        bit_q, bit_d;
  logic              ws_q, ws_d;
  logic              rdy0_q, rdy0_d;
  logic              rdy1_q, rdy1_d;
  logic [1:0]        unf_q, unf_d;

  logic              div_tick, div_fall, div_sck;
  logic              adv, last_bit;
  logic              load0, load1;
  logic              ld_valid;
  logic [31:0]       ld_word;

  cbi980_clkdiv u_clkdiv (
    .clk     (clk),
    .rst     (rst),
    .clear_i (state_q == ST_IDLE),
    .rate_i  (rate_q),
    .tick_o  (div_tick),
    .fall_o  (div_fall),
    .sck_o   (div_sck)
  );

  always_comb begin
    state_d  = state_q;
    rate_d   = rate_q;
    oct_d    = oct_q;
    rjust_d  = rjust_q;
    lsb_d    = lsb_q;
    sh_d     = sh_q;
    bit_d    = bit_q;
    ws_d     = ws_q;
    rdy0_d   = 1'b0;
    rdy1_d   = 1'b0;
    unf_d    = '0;
    load0    = 1'b0;
    load1    = 1'b0;
    ld_valid = 1'b0;
    ld_word  = '0;
    adv      = div_tick && div_fall;
    last_bit = (bit_q == ({oct_q, 3'b000} - 6'd1));

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_SLOT0;
          load0   = 1'b1;
        end
      end
      ST_SLOT0: begin
        if (adv) begin
          if (last_bit) begin
            state_d = ST_SLOT1;
            load1   = 1'b1;
          end else begin
            sh_d  = {sh_q[30:0], 1'b0};
            bit_d = bit_q + 6'd1;
          end
        end
      end
      ST_SLOT1: begin
        if (adv) begin
          if (last_bit && en) begin
            state_d = ST_SLOT0;
            load0   = 1'b1;
          end else if (last_bit) begin
            state_d = ST_IDLE;
            sh_d    = '0;
            bit_d   = '0;
            ws_d    = 1'b0;
          end else begin
            sh_d  = {sh_q[30:0], 1'b0};
            bit_d = bit_q + 6'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load0) begin
      rate_d  = mclk_rate;
      oct_d   = clamp_octets(octet_cnt);
      rjust_d = rjust;
      lsb_d   = lsb_first;
    end

    // Slot entry: the first bit must appear together with the new ws and
    // ready, so the word is ordered using the configuration latched at
    // this same edge (the _d values).
    if (load0 || load1) begin
      ld_valid = load1 ? t1_valid : t0_valid;
      ld_word  = load1 ? t1_data[31:0] : t0_data[31:0];
      sh_d     = ld_valid ? order_slot(ld_word, oct_d, rjust_d, lsb_d) : '0;
      bit_d    = '0;
      ws_d     = load1;
      rdy0_d   = load0;
      rdy1_d   = load1;
      unf_d    = {load1 & ~ld_valid, load0 & ~ld_valid};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rate_q  <= '0;
      oct_q   <= OCT_MIN;
      rjust_q <= 1'b0;
      lsb_q   <= 1'b0;
      sh_q    <= '0;
      bit_q   <= '0;
      ws_q    <= 1'b0;
      rdy0_q  <= 1'b0;
      rdy1_q  <= 1'b0;
      unf_q   <= '0;
    end else begin
      state_q <= state_d;
      rate_q  <= rate_d;
      oct_q   <= oct_d;
      rjust_q <= rjust_d;
      lsb_q   <= lsb_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      ws_q    <= ws_d;
      rdy0_q  <= rdy0_d;
      rdy1_q  <= rdy1_d;
      unf_q   <= unf_d;
    end
  end

  assign sck      = div_sck;
  assign ws       = ws_q;
  assign sd       = sh_q[31];
  assign t0_ready = rdy0_q;
  assign t1_ready = rdy1_q;
  assign tx_unf   = unf_q;

endmodule

// File: tb/tb_cbi980_tx_serializer.sv
// Bench for cbi980_tx_serializer: each slot's expected bit sequence, channel,
// underflow flag and timing are queued when the FIFO words are presented and
// compared by a monitor as the DUT emits the slot.
module tb_cbi980_tx_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  mclk_rate = '0;
  logic [2:0]  octet_cnt = '0;
  logic        rjust = 1'b0;
  logic        lsb_first = 1'b0;
  logic [31:0] t0_data = '0;
  logic [31:0] t1_data = '0;
  logic        t0_valid = 1'b0;
  logic        t1_valid = 1'b0;
  logic        t0_ready, t1_ready, sck, ws, sd;
  logic [1:0]  tx_unf;

  cbi980_tx_serializer #(.WORD_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mclk_rate (mclk_rate),
    .octet_cnt (octet_cnt),
    .rjust     (rjust),
    .lsb_first (lsb_first),
    .t0_data   (t0_data),
    .t1_data   (t1_data),
    .t0_valid  (t0_valid),
    .t1_valid  (t1_valid),
    .t0_ready  (t0_ready),
    .t1_ready  (t1_ready),
    .sck       (sck),
    .ws        (ws),
    .sd        (sd),
    .tx_unf    (tx_unf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // bits[i] is the i-th bit the slot must put on sd.
  typedef struct {
    bit          ch;
    bit          unf;
    logic [31:0] bits;
    int          n;
    int          p;
    bit          first;
  } exp_t;

  exp_t q[$];

  function automatic int slot_len(input int oct);
    if (oct == 0) return 8;
    if (oct > 4)  return 32;
    return 8 * oct;
  endfunction

  function automatic exp_t mk(input bit ch, input logic [31:0] w, input bit v, input int rate,
                              input int oct, input bit rj, input bit lsb, input bit first);
    exp_t e;
    int base, idx;
    e.ch    = ch;
    e.unf   = !v;
    e.n     = slot_len(oct);
    e.p     = 1 << rate;
    e.first = first;
    e.bits  = '0;
    base    = rj ? 0 : 32 - e.n;
    if (v) begin
      for (int i = 0; i < e.n; i++) begin
        idx = lsb ? base + i : base + e.n - 1 - i;
        e.bits[i] = w[idx];
      end
    end
    return e;
  endfunction

  // Monitor: samples on the falling clock edge.
  exp_t cur;
  bit   active = 1'b0;
  bit   prev_sck = 1'b0;
  int   off = 0;
  int   bitn = 0;
  int   prev_n, prev_p;
  bit   had_prev;

  always @(negedge clk) begin
    if (!rst) begin
      active   = 1'b0;
      prev_sck = 1'b0;
    end else begin
      if (t0_ready || t1_ready) begin
        if (t0_ready && t1_ready) chk("rdy_both", 1, 0);
        had_prev = active;
        prev_n   = cur.n;
        prev_p   = cur.p;
        if (q.size() == 0) begin
          chk("unexp_ready", {t1_ready, t0_ready}, 0);
          active = 1'b0;
        end else begin
          cur = q.pop_front();
          chk("rdy_ch", t1_ready, cur.ch);
          chk("ws_entry", ws, cur.ch);
          chk("unf", tx_unf, cur.unf ? (cur.ch ? 2 : 1) : 0);
          if (!cur.first && had_prev) chk("gap", off + 1, 2 * prev_p * prev_n);
          active = 1'b1;
          off    = 0;
          bitn   = 0;
        end
      end else begin
        if (tx_unf != 2'b00) chk("unf_stray", tx_unf, 0);
        if (active) off++;
      end
      if (active && !prev_sck && sck) begin
        if (bitn < cur.n) begin
          chk($sformatf("sd_ch%0d_b%0d", cur.ch, bitn), sd, cur.bits[bitn]);
          chk("ws_hold", ws, cur.ch);
          chk("bit_time", off, cur.p + 2 * cur.p * bitn);
          bitn++;
        end else begin
          chk("extra_bit", bitn, cur.n);
        end
      end
      prev_sck = sck;
    end
  end

  task automatic wait_ready(input bit ch);
    bit seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      seen = ch ? t1_ready : t0_ready;
    end
    if (!seen) chk($sformatf("timeout_rdy%0d", ch), 0, 1);
  endtask

  task automatic idle_check(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk("idle_out", {sck, ws, sd, t0_ready, t1_ready, tx_unf}, 0);
    end
  endtask

  // Called on a falling edge, either from idle or right after the previous
  // frame's channel-1 pop. Configuration inputs are scrambled mid-frame;
  // they must only take effect at the next channel-0 slot.
  task automatic send_frame(input logic [31:0] a, input bit va, input logic [31:0] b, input bit vb,
                            input int rate, input int oct, input bit rj, input bit lsb,
                            input bit keep_en);
    bit from_idle;
    from_idle = !en;
    mclk_rate = 3'(rate);
    octet_cnt = 3'(oct);
    rjust     = rj;
    lsb_first = lsb;
    t0_data   = a;
    t0_valid  = va;
    q.push_back(mk(1'b0, a, va, rate, oct, rj, lsb, from_idle));
    en = 1'b1;
    wait_ready(1'b0);
    t0_data   = $urandom;
    mclk_rate = 3'($urandom_range(0, 7));
    octet_cnt = 3'($urandom_range(0, 7));
    rjust     = 1'($urandom);
    lsb_first = 1'($urandom);
    t1_data   = b;
    t1_valid  = vb;
    q.push_back(mk(1'b1, b, vb, rate, oct, rj, lsb, 1'b0));
    en = keep_en;
    wait_ready(1'b1);
    t1_data = $urandom;
    if (!keep_en) begin
      repeat (2 * (1 << rate) * slot_len(oct) + 2) @(negedge clk);
      chk("drained", q.size(), 0);
      idle_check(16);
    end
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out", {sck, ws, sd, t0_ready, t1_ready, tx_unf}, 0);
    rst = 1'b1;
    idle_check(4);

    send_frame(32'hA500_0000, 1, $urandom, 1, 0, 1, 0, 0, 1);
    send_frame($urandom, 1, 32'h0000_1234, 1, 1, 2, 1, 1, 1);
    send_frame($urandom, 1, $urandom, 0, 0, 1, 0, 0, 1);
    send_frame($urandom, 0, $urandom, 1, 0, 0, 1, 0, 1);
    send_frame($urandom, 1, $urandom, 1, 0, 7, 0, 1, 1);
    for (int i = 0; i < 3; i++)
      send_frame($urandom, 1, $urandom, 1, $urandom_range(0, 2), $urandom_range(0, 7),
                 1'($urandom), 1'($urandom), 1);
    send_frame($urandom, 1, $urandom, 1, 2, 4, 0, 0, 0);

    // Asynchronous reset in the middle of bit 5 of a channel-0 slot.
    mclk_rate = 3'd0;
    octet_cnt = 3'd1;
    rjust     = 1'b0;
    lsb_first = 1'b0;
    t0_data   = 32'hFF00_0000;
    t0_valid  = 1'b1;
    q.push_back(mk(1'b0, 32'hFF00_0000, 1, 0, 1, 0, 0, 1));
    en = 1'b1;
    wait_ready(1'b0);
    repeat (10) @(posedge clk);
    #3 rst = 1'b0;
    #1 chk("rst_async", {sck, ws, sd, t0_ready, t1_ready, tx_unf}, 0);
    en = 1'b0;
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle_check(6);
    send_frame($urandom, 1, $urandom, 1, 0, 2, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
